// File: rtl/serial_sub.sv
// Bit-serial subtractor: A - B, LSB first, one full-subtractor cell plus a borrow flop.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Handshake: start is honoured only in IDLE or DONE; busy covers the WIDTH bit-cycles,
  // done is a one-cycle pulse with diff/borrow valid, and start in the DONE cycle chains a new op.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b, res;
  logic [CW-1:0]    count;
  logic             br;

  logic a0, b0, d, br_next, last, load;

  always_comb begin
    a0      = op_a[0];
    b0      = op_b[0];
    d       = a0 ^ b0 ^ br;
    br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
    last    = (count == LAST);
    load    = start && (state == IDLE || state == DONE);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      count  <= '0;
      br     <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (load) begin
      op_a  <= a;
      op_b  <= b;
      res   <= '0;
      count <= '0;
      br    <= 1'b0;
    end else if (state == SHIFT) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      res   <= {d, res[WIDTH-1:1]};
      br    <= br_next;
      count <= count + CW'(1);
      // The final bit-cycle publishes the result; diff/borrow hold otherwise.
      if (last) begin
        diff   <= {d, res[WIDTH-1:1]};
        borrow <= br_next;
`ifdef SERIAL_SUB_OVF_EN
        ovf    <= br ^ br_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: vector table, random ops against an arithmetic model,
// and hand-written sequences for ignored start, back-to-back ops and mid-op reset.
module tb_serial_sub;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_sub #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .diff(diff),
    .borrow(borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [W+1:0] exp_q[$];
  logic [W-1:0] last_diff;
  logic         last_borrow;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned and signed arithmetic, packed as {ovf, borrow, diff}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int           ux, uy, sd;
    logic [W-1:0] d;
    logic         bo, ov;
    ux = int'(x);
    uy = int'(y);
    d  = W'((ux - uy + (1 << W)) % (1 << W));
    bo = (ux < uy);
    sd = int'($signed(x)) - int'($signed(y));
    ov = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    return {ov, bo, d};
  endfunction

  // driver: assert start for one cycle from the current negedge, then scramble operands
  task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  // Called at the negedge right after the accepting edge; returns at the done negedge.
  task automatic watch(input string name, input int poke_at);
    int           n;
    logic         hold_ok, busy_ok;
    logic [W+1:0] e;
    n       = 0;
    hold_ok = 1'b1;
    busy_ok = 1'b1;
    check($sformatf("%s busy_at_accept", name), busy, 1);
    while (!done && n < W + 4) begin
      if (diff !== last_diff || borrow !== last_borrow) hold_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (n == poke_at) begin
        start = 1'b1;
        a     = 8'h00;
        b     = 8'h01;
      end
      @(negedge clk);
      n++;
      if (n == poke_at + 1) start = 1'b0;
    end
    check($sformatf("%s latency", name), n, W);
    check($sformatf("%s hold_during_shift", name), hold_ok, 1);
    check($sformatf("%s busy_during_shift", name), busy_ok, 1);
    check($sformatf("%s busy_at_done", name), busy, 0);
    if (exp_q.size() == 0) begin
      check($sformatf("%s queue_nonempty", name), 0, 1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("%s diff", name), diff, e[W-1:0]);
      check($sformatf("%s borrow", name), borrow, e[W]);
`ifdef SERIAL_SUB_OVF_EN
      check($sformatf("%s ovf", name), ovf, e[W+1]);
`endif
      last_diff   = e[W-1:0];
      last_borrow = e[W];
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W+1:0] e);
    @(negedge clk);
    exp_q.push_back(e);
    drive_start(x, y);
    watch(name, -1);
    @(negedge clk);
    check($sformatf("%s done_one_cycle", name), done, 0);
  endtask

  initial begin
    int extra;
    logic [W-1:0] x, y;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h40, 8'h10, 8'h30, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};

    rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    last_diff   = '0;
    last_borrow = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset diff", diff, 0);
    check("reset borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset ovf", ovf, 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
             {vecs[i].ovf, vecs[i].borrow, vecs[i].diff});

    // start while busy is ignored, exactly one done pulse
    @(negedge clk);
    exp_q.push_back({1'b0, 1'b0, 8'h30});
    drive_start(8'h40, 8'h10);
    watch("ignored_start", 3);
    extra = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("ignored_start extra_done", extra, 0);
    check("ignored_start idle_busy", busy, 0);

    // back-to-back: start held in the done cycle
    @(negedge clk);
    exp_q.push_back(model(8'h05, 8'h03));
    drive_start(8'h05, 8'h03);
    watch("b2b_first", -1);
    exp_q.push_back({1'b0, 1'b0, 8'h0F});
    drive_start(8'h10, 8'h01);
    watch("b2b_second", -1);
    @(negedge clk);
    check("b2b done_one_cycle", done, 0);

    // reset in the middle of an operation
    @(negedge clk);
    drive_start(8'h55, 8'h22);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst diff", diff, 0);
    check("midrst borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("midrst ovf", ovf, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    last_diff   = '0;
    last_borrow = 1'b0;
    extra = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("midrst no_done", extra, 0);
    run_op("after_rst", 8'h09, 8'h04, {1'b0, 1'b0, 8'h05});

    // randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom_range(0, (1 << W) - 1));
      y = W'($urandom_range(0, (1 << W) - 1));
      run_op($sformatf("rand%0d_%0h_%0h", i, x, y), x, y, model(x, y));
    end

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
